// File: rtl/sa_autosa_shiftright_ctrl.sv
// -----------------------------------------------------------------------------
// sa_autosa_shiftright_ctrl
//
// Per-channel shift sequencer around the unsigned shift-right/saturate
// function. Each accepted beat looks up its channel's signed shift amount,
// is converted combinationally from stage 1 and registered into stage 2,
// which drives the output stream. Saturated beats are flagged and counted.
//
// Ports:
//   autosa_core_clk   clock
//   autosa_core_rstn  asynchronous active-low reset
//   cfg_op_en         1 = accept new input beats
//   cfg_we/cfg_ch/cfg_shift  shift table write port
//   sat_cnt_clr       synchronous clear of sat_cnt
//   in_pvld/in_prdy/in_data/in_ch       input stream (data + channel tag)
//   out_pvld/out_prdy/out_data/out_frac/out_sat  output stream
//   sat_cnt           count of saturated output handshakes (sticks at max)
//   idle              both pipeline stages empty
// -----------------------------------------------------------------------------
module sa_autosa_shiftright_ctrl #(
   parameter int IN_WIDTH    = 49,
   parameter int OUT_WIDTH   = 32,
   parameter int FRAC_WIDTH  = 35,
   parameter int SHIFT_WIDTH = 6,
   parameter int CH_NUM      = 4,
   parameter int CH_WIDTH    = 2,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   autosa_core_clk,
   input  logic                   autosa_core_rstn,
   input  logic                   cfg_op_en,
   input  logic                   cfg_we,
   input  logic [CH_WIDTH-1:0]    cfg_ch,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic                   sat_cnt_clr,
   input  logic                   in_pvld,
   output logic                   in_prdy,
   input  logic [IN_WIDTH-1:0]    in_data,
   input  logic [CH_WIDTH-1:0]    in_ch,
   output logic                   out_pvld,
   input  logic                   out_prdy,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic [FRAC_WIDTH-1:0]  out_frac,
   output logic                   out_sat,
   output logic [CNT_WIDTH-1:0]   sat_cnt,
   output logic                   idle
);

   // Largest left shift is 2^(SHIFT_WIDTH-1); the working value is wide
   // enough that no set bit is ever lost before the saturation test.
   localparam int MAX_LSH = 2 ** (SHIFT_WIDTH - 1);
   localparam int WIDE_W  = IN_WIDTH + MAX_LSH;

   logic [SHIFT_WIDTH-1:0] shift_tab [CH_NUM];
   logic [SHIFT_WIDTH-1:0] tab_rd;

   logic                   s1_vld;
   logic [IN_WIDTH-1:0]    s1_data;
   logic [SHIFT_WIDTH-1:0] s1_shift;

   logic                   in_hs;
   logic                   s2_adv;
   logic                   out_hs;

   logic [SHIFT_WIDTH-1:0] sh_mag;
   logic [WIDE_W-1:0]      sh_wide;
   logic [OUT_WIDTH-1:0]   sh_data;
   logic [FRAC_WIDTH-1:0]  sh_frac;
   logic                   sh_sat;

   // ---------------------------------------------------------------------
   // Handshakes / stage advance
   // ---------------------------------------------------------------------
   assign s2_adv  = s1_vld & (!out_pvld | out_prdy);
   assign in_prdy = autosa_core_rstn & cfg_op_en & (!s1_vld | s2_adv);
   assign in_hs   = in_pvld & in_prdy;
   assign out_hs  = out_pvld & out_prdy;
   assign idle    = !s1_vld & !out_pvld;

   // ---------------------------------------------------------------------
   // Shift table. Out-of-range indices match no entry, so such writes are
   // dropped and such reads return 0.
   // ---------------------------------------------------------------------
   // NOTE: the table is a handful of flops, not RAM, so every entry is reset;
   // a mid-stream reset must bring all channels back to shift 0.
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         for (int i = 0; i < CH_NUM; i++) shift_tab[i] <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < CH_NUM; i++)
            if (cfg_ch == CH_WIDTH'(i)) shift_tab[i] <= cfg_shift;
      end
   end

   // NOTE: every combinational output gets a default first so no path
   // through the block leaves a variable unassigned (no latch).
   always_comb begin
      tab_rd = '0;
      for (int i = 0; i < CH_NUM; i++)
         if (in_ch == CH_WIDTH'(i)) tab_rd = shift_tab[i];
   end

   // ---------------------------------------------------------------------
   // Stage 1: the beat plus its shift, read before any same-edge table write.
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample pre-edge values, which is what gives the old-value read above.
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         s1_vld   <= 1'b0;
         s1_data  <= '0;
         s1_shift <= '0;
      end else if (in_hs) begin
         s1_vld   <= 1'b1;
         s1_data  <= in_data;
         s1_shift <= tab_rd;
      end else if (s2_adv) begin
         s1_vld   <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Shift/saturate on stage 1 contents. Negative shift = left shift with a
   // zero fraction; positive shift keeps the shifted-out bits MSB-aligned.
   // ---------------------------------------------------------------------
   always_comb begin
      sh_mag  = '0;
      sh_wide = '0;
      sh_frac = '0;
      if (s1_shift[SHIFT_WIDTH-1]) begin
         sh_mag  = -s1_shift;
         sh_wide = WIDE_W'(s1_data) << sh_mag;
      end else begin
         sh_wide = WIDE_W'(s1_data) >> s1_shift;
         sh_frac = FRAC_WIDTH'({s1_data, {FRAC_WIDTH{1'b0}}} >> s1_shift);
      end
      sh_sat  = |sh_wide[WIDE_W-1:OUT_WIDTH];
      sh_data = sh_sat ? '1 : sh_wide[OUT_WIDTH-1:0];
   end

   // ---------------------------------------------------------------------
   // Stage 2: registered outputs, held while stalled.
   // ---------------------------------------------------------------------
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         out_pvld <= 1'b0;
         out_data <= '0;
         out_frac <= '0;
         out_sat  <= 1'b0;
      end else if (s2_adv) begin
         out_pvld <= 1'b1;
         out_data <= sh_data;
         out_frac <= sh_frac;
         out_sat  <= sh_sat;
      end else if (out_prdy) begin
         out_pvld <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Saturation counter: clear wins, increment sticks at all ones.
   // ---------------------------------------------------------------------
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         sat_cnt <= '0;
      end else if (sat_cnt_clr) begin
         sat_cnt <= '0;
      end else if (out_hs && out_sat && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sa_autosa_shiftright_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sa_autosa_shiftright_ctrl
//
// Scenario tasks drive the DUT; every accepted beat pushes its expected
// result (from an arithmetic reference model, or explicit constants) into a
// scoreboard queue that the output monitor pops on each output handshake.
// -----------------------------------------------------------------------------
module tb_sa_autosa_shiftright_ctrl;

   localparam int IN_WIDTH    = 49;
   localparam int OUT_WIDTH   = 32;
   localparam int FRAC_WIDTH  = 35;
   localparam int SHIFT_WIDTH = 6;
   localparam int CH_NUM      = 4;
   localparam int CH_WIDTH    = 2;
   localparam int CNT_WIDTH   = 32;

   typedef struct packed {
      logic [OUT_WIDTH-1:0]  data;
      logic [FRAC_WIDTH-1:0] frac;
      logic                  sat;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   cfg_op_en = 1'b1;
   logic                   cfg_we = 1'b0;
   logic [CH_WIDTH-1:0]    cfg_ch = '0;
   logic [SHIFT_WIDTH-1:0] cfg_shift = '0;
   logic                   sat_cnt_clr = 1'b0;
   logic                   in_pvld = 1'b0;
   logic                   in_prdy;
   logic [IN_WIDTH-1:0]    in_data = '0;
   logic [CH_WIDTH-1:0]    in_ch = '0;
   logic                   out_pvld;
   logic                   out_prdy = 1'b1;
   logic [OUT_WIDTH-1:0]   out_data;
   logic [FRAC_WIDTH-1:0]  out_frac;
   logic                   out_sat;
   logic [CNT_WIDTH-1:0]   sat_cnt;
   logic                   idle;

   int   tests = 0;
   int   fails = 0;
   int   accepted = 0;
   int   cyc_cnt = 0;
   int   exp_cnt = 0;
   exp_t sb [$];
   logic [SHIFT_WIDTH-1:0] tb_tab [CH_NUM];

   sa_autosa_shiftright_ctrl #(
      .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_WIDTH(FRAC_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH), .CH_NUM(CH_NUM), .CH_WIDTH(CH_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .autosa_core_clk(clk), .autosa_core_rstn(rstn), .cfg_op_en(cfg_op_en),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
      .sat_cnt_clr(sat_cnt_clr), .in_pvld(in_pvld), .in_prdy(in_prdy),
      .in_data(in_data), .in_ch(in_ch), .out_pvld(out_pvld),
      .out_prdy(out_prdy), .out_data(out_data), .out_frac(out_frac),
      .out_sat(out_sat), .sat_cnt(sat_cnt), .idle(idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: shift by division/multiplication on a 128-bit value.
   function automatic exp_t model(input logic [IN_WIDTH-1:0] d,
                                  input logic [SHIFT_WIDTH-1:0] s);
      logic [127:0] dd, v, rem;
      int   n;
      exp_t e;
      dd  = 128'(d);
      rem = '0;
      if (s[SHIFT_WIDTH-1]) begin
         n = (1 << SHIFT_WIDTH) - int'(s);
         v = dd * (128'd1 << n);
      end else begin
         n   = int'(s);
         v   = dd / (128'd1 << n);
         rem = dd % (128'd1 << n);
      end
      e.sat  = (v > 128'hFFFF_FFFF);
      e.data = e.sat ? 32'hFFFF_FFFF : v[31:0];
      e.frac = s[SHIFT_WIDTH-1] ? '0 : FRAC_WIDTH'(rem << (FRAC_WIDTH - n));
      return e;
   endfunction

   // Output monitor: a handshake happens at the coming posedge.
   always @(negedge clk) begin
      if (sat_cnt_clr) exp_cnt = 0;
      if (rstn && out_pvld && out_prdy) begin
         exp_t e;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got data=%h frac=%h sat=%b, required none",
                     out_data, out_frac, out_sat);
         end else begin
            e = sb.pop_front();
            if (e.sat && !sat_cnt_clr && exp_cnt < 32'hFFFF_FFFF) exp_cnt++;
            if (out_data !== e.data || out_frac !== e.frac || out_sat !== e.sat) begin
               fails++;
               $display("FAIL beat: got data=%h frac=%h sat=%b, required data=%h frac=%h sat=%b",
                        out_data, out_frac, out_sat, e.data, e.frac, e.sat);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_tab(input int ch, input logic [SHIFT_WIDTH-1:0] val);
      cfg_we    = 1'b1;
      cfg_ch    = CH_WIDTH'(ch);
      cfg_shift = val;
      cyc();
      cfg_we    = 1'b0;
      tb_tab[ch] = val;
   endtask

   // Present one beat and hold it until accepted; pushes the model result.
   task automatic send(input int ch, input logic [IN_WIDTH-1:0] d);
      bit ok = 0;
      in_pvld = 1'b1;
      in_ch   = CH_WIDTH'(ch);
      in_data = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_prdy) begin
            sb.push_back(model(d, tb_tab[ch]));
            @(posedge clk);
            #1;
            ok = 1;
         end
      end
      in_pvld = 1'b0;
      if (ok) accepted++;
      else begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got in_prdy=%b, required 1", in_prdy);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && idle) return;
         cyc();
      end
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
   endtask

   task automatic test_reset();
      for (int i = 0; i < CH_NUM; i++) tb_tab[i] = '0;
      rstn = 1'b0;
      repeat (2) cyc();
      tests++;
      if (in_prdy !== 1'b0 || out_pvld !== 1'b0 || out_data !== '0 || out_frac !== '0 ||
          out_sat !== 1'b0 || sat_cnt !== '0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL reset_values: got prdy=%b pvld=%b data=%h frac=%h sat=%b cnt=%0d idle=%b, required 0 0 0 0 0 0 1",
                  in_prdy, out_pvld, out_data, out_frac, out_sat, sat_cnt, idle);
      end
      rstn = 1'b1;
      cyc();
      tests++;
      if (in_prdy !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_prdy: got %b, required 1", in_prdy);
      end
   endtask

   task automatic test_right_shift();
      write_tab(0, 6'd4);
      in_pvld = 1'b1;
      in_ch   = 2'd0;
      in_data = 49'h1234;
      @(negedge clk);
      tests++;
      if (in_prdy !== 1'b1) begin
         fails++;
         $display("FAIL rs_prdy: got %b, required 1", in_prdy);
      end
      sb.push_back('{data: 32'h123, frac: 35'h2_0000_0000, sat: 1'b0});
      @(posedge clk);
      #1;
      in_pvld = 1'b0;
      tests++;
      if (out_pvld !== 1'b0) begin
         fails++;
         $display("FAIL rs_latency_early: got out_pvld=%b, required 0", out_pvld);
      end
      cyc();
      tests++;
      if (out_pvld !== 1'b1 || out_data !== 32'h123 || out_frac !== 35'h2_0000_0000 || out_sat !== 1'b0) begin
         fails++;
         $display("FAIL rs_result: got pvld=%b data=%h frac=%h sat=%b, required 1 123 200000000 0",
                  out_pvld, out_data, out_frac, out_sat);
      end
      drain();
   endtask

   task automatic test_left_shift();
      write_tab(1, 6'h3D);
      send(1, 49'h10);
      drain();
      write_tab(1, 6'h20);
      send(1, 49'h1);
      drain();
      tests++;
      if (sat_cnt !== 32'd1) begin
         fails++;
         $display("FAIL ls_sat_cnt: got %0d, required 1", sat_cnt);
      end
   endtask

   task automatic test_right_sat();
      write_tab(2, 6'd0);
      send(2, 49'h1_0000_0000);
      drain();
      tests++;
      if (sat_cnt !== 32'd2) begin
         fails++;
         $display("FAIL rsat_cnt: got %0d, required 2", sat_cnt);
      end
      // Park a saturated beat in S2, then clear in its handshake cycle.
      out_prdy = 1'b0;
      send(2, 49'h1_FFFF_FFFF_FFFF);
      cyc();
      tests++;
      if (out_pvld !== 1'b1 || out_sat !== 1'b1 || out_data !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL rsat_parked: got pvld=%b sat=%b data=%h, required 1 1 ffffffff",
                  out_pvld, out_sat, out_data);
      end
      out_prdy    = 1'b1;
      sat_cnt_clr = 1'b1;
      cyc();
      sat_cnt_clr = 1'b0;
      tests++;
      if (sat_cnt !== 32'd0) begin
         fails++;
         $display("FAIL clr_priority: got %0d, required 0", sat_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      write_tab(0, 6'd3);
      write_tab(1, 6'h3B);
      write_tab(2, 6'd31);
      write_tab(3, 6'd0);
      out_prdy = 1'b1;
      t0 = cyc_cnt;
      for (int i = 0; i < 8; i++)
         send(i % CH_NUM, ($urandom_range(0, 1) == 0) ? 49'($urandom_range(0, 65535))
                                                       : 49'({$urandom(), $urandom()}));
      tests++;
      if (cyc_cnt - t0 !== 8) begin
         fails++;
         $display("FAIL throughput: got %0d cycles for 8 beats, required 8", cyc_cnt - t0);
      end
      drain();
      // Restore table[3] to 0 for the config race scenario.
      write_tab(3, 6'd0);
   endtask

   task automatic test_backpressure();
      logic [OUT_WIDTH-1:0]  d0;
      logic [FRAC_WIDTH-1:0] f0;
      logic                  s0;
      out_prdy = 1'b0;
      accepted = 0;
      fork
         begin
            for (int i = 0; i < 5; i++) send(0, 49'(32'h1000 * (i + 1) + i));
         end
         begin
            repeat (3) cyc();
            d0 = out_data;
            f0 = out_frac;
            s0 = out_sat;
            repeat (3) cyc();
            tests++;
            if (accepted !== 2 || in_prdy !== 1'b0 || out_pvld !== 1'b1) begin
               fails++;
               $display("FAIL bp_stall: got accepted=%0d prdy=%b pvld=%b, required 2 0 1",
                        accepted, in_prdy, out_pvld);
            end
            tests++;
            if (out_data !== d0 || out_frac !== f0 || out_sat !== s0) begin
               fails++;
               $display("FAIL bp_stable: got %h/%h/%b, required %h/%h/%b",
                        out_data, out_frac, out_sat, d0, f0, s0);
            end
            out_prdy = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_random_backpressure();
      bit done = 0;
      fork
         begin
            for (int i = 0; i < 24; i++)
               send($urandom_range(0, CH_NUM - 1),
                    ($urandom_range(0, 2) == 0) ? 49'({$urandom(), $urandom()})
                                                : 49'($urandom_range(0, 1 << 20)));
            done = 1;
         end
         begin
            while (!done) begin
               out_prdy = ($urandom_range(0, 2) != 0);
               cyc();
            end
         end
      join
      out_prdy = 1'b1;
      drain();
   endtask

   task automatic test_config_race();
      out_prdy  = 1'b1;
      in_pvld   = 1'b1;
      in_ch     = 2'd3;
      in_data   = 49'h40;
      cfg_we    = 1'b1;
      cfg_ch    = 2'd3;
      cfg_shift = 6'd2;
      @(negedge clk);
      tests++;
      if (in_prdy !== 1'b1) begin
         fails++;
         $display("FAIL race_prdy: got %b, required 1", in_prdy);
      end
      sb.push_back('{data: 32'h40, frac: '0, sat: 1'b0});
      @(posedge clk);
      #1;
      in_pvld   = 1'b0;
      cfg_we    = 1'b0;
      tb_tab[3] = 6'd2;
      in_pvld   = 1'b1;
      @(negedge clk);
      sb.push_back('{data: 32'h10, frac: '0, sat: 1'b0});
      @(posedge clk);
      #1;
      in_pvld = 1'b0;
      drain();
   endtask

   task automatic test_op_en();
      cfg_op_en = 1'b0;
      in_pvld   = 1'b1;
      in_ch     = 2'd0;
      repeat (3) cyc();
      tests++;
      if (in_prdy !== 1'b0 || idle !== 1'b1) begin
         fails++;
         $display("FAIL op_en_off: got prdy=%b idle=%b, required 0 1", in_prdy, idle);
      end
      in_pvld   = 1'b0;
      cfg_op_en = 1'b1;
   endtask

   task automatic test_mid_reset();
      out_prdy = 1'b0;
      send(0, 49'h5555);
      send(1, 49'h7);
      tests++;
      if (out_pvld !== 1'b1 || idle !== 1'b0) begin
         fails++;
         $display("FAIL mr_full: got pvld=%b idle=%b, required 1 0", out_pvld, idle);
      end
      rstn = 1'b0;
      #1;
      tests++;
      if (out_pvld !== 1'b0 || idle !== 1'b1 || sat_cnt !== '0) begin
         fails++;
         $display("FAIL mr_async: got pvld=%b idle=%b cnt=%0d, required 0 1 0",
                  out_pvld, idle, sat_cnt);
      end
      sb.delete();
      exp_cnt = 0;
      for (int i = 0; i < CH_NUM; i++) tb_tab[i] = '0;
      cyc();
      rstn     = 1'b1;
      out_prdy = 1'b1;
      cyc();
      send(0, 49'h1234);
      send(1, 49'h10);
      drain();
   endtask

   initial begin
      test_reset();
      test_right_shift();
      test_left_shift();
      test_right_sat();
      test_back_to_back();
      test_backpressure();
      test_random_backpressure();
      test_config_race();
      test_op_en();
      tests++;
      if (sat_cnt !== CNT_WIDTH'(exp_cnt)) begin
         fails++;
         $display("FAIL sat_cnt_track: got %0d, required %0d", sat_cnt, exp_cnt);
      end
      test_mid_reset();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL leftover: got %0d pending beats, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
